ex_stage: RTL and testbench

- Execute stage of the 5-stage LoongArch32 pipeline; consumes the decoded bundle from the ID stage and produces a write-back result for the MEM stage.
- Contains the ALU, a single-cycle multiplier and a 32-iteration restoring divider with its own FSM.
- Issues data-SRAM requests for ld.w/st.w.
- Drives the EX-stage hazard/forwarding signals back to ID.

---
 rtl/ex_stage_pkg.sv | 35 +++
 rtl/ex_stage_if.sv | 10 +
 rtl/ex_divider.sv | 82 ++++++++
 rtl/ex_stage.sv | 137 +++++++++++++
 tb/tb_ex_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the EX stage: ALU op bit positions, memory op codes,
// divider FSM encoding.
package ex_stage_pkg;

  localparam int ALU_OP_W    = 19;
  localparam int ALU_OP_ADD  = 0;
  localparam int ALU_OP_SUB  = 1;
  localparam int ALU_OP_SLT  = 2;
  localparam int ALU_OP_SLTU = 3;
  localparam int ALU_OP_AND  = 4;
  localparam int ALU_OP_NOR  = 5;
  localparam int ALU_OP_OR   = 6;
  localparam int ALU_OP_XOR  = 7;
  localparam int ALU_OP_SLL  = 8;
  localparam int ALU_OP_SRL  = 9;
  localparam int ALU_OP_SRA  = 10;
  localparam int ALU_OP_LUI  = 11;
  localparam int ALU_OP_MUL  = 12;
  localparam int ALU_OP_MULH = 13;
  localparam int ALU_OP_MULHU= 14;
  localparam int ALU_OP_DIV  = 15;
  localparam int ALU_OP_MOD  = 16;
  localparam int ALU_OP_DIVU = 17;
  localparam int ALU_OP_MODU = 18;

  localparam logic [1:0] MEM_EN_STORE = 2'b11;
  localparam logic [1:0] MEM_EN_LOAD  = 2'b01;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Data-SRAM request bus driven by the EX stage.
interface ex_stage_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
  modport slave  (input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
endinterface

// File: rtl/ex_divider.sv
// Restoring divider, one quotient bit per cycle; operands are made positive
// on entry and the signs are restored on the final step.
module ex_divider
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic        i_ack,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);
  localparam int CNT_W = $clog2(DIV_ITER + 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_quo, r_rem, r_div;
  logic             r_q_neg, r_r_neg;

  logic        w_a_neg, w_b_neg, w_ge;
  logic [31:0] w_abs_a, w_abs_b, w_diff, w_quo_nx, w_rem_nx;

  assign w_a_neg = i_signed & i_a[31];
  assign w_b_neg = i_signed & i_b[31];
  assign w_abs_a = w_a_neg ? -i_a : i_a;
  assign w_abs_b = w_b_neg ? -i_b : i_b;

  // Partial remainder is kept < divisor, so the 33-bit trial fits after a hit.
  assign w_ge     = {r_rem, r_quo[31]} >= {1'b0, r_div};
  assign w_diff   = {r_rem[30:0], r_quo[31]} - r_div;
  assign w_rem_nx = w_ge ? w_diff : {r_rem[30:0], r_quo[31]};
  assign w_quo_nx = {r_quo[30:0], w_ge};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: if (i_start) begin
          r_state <= DIV_BUSY;
          r_cnt   <= '0;
          r_quo   <= w_abs_a;
          r_rem   <= '0;
          r_div   <= w_abs_b;
          r_q_neg <= w_a_neg ^ w_b_neg;
          r_r_neg <= w_a_neg;
        end
        DIV_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
            r_state <= DIV_DONE;
            r_quo   <= r_q_neg ? -w_quo_nx : w_quo_nx;
            r_rem   <= r_r_neg ? -w_rem_nx : w_rem_nx;
          end else begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
          end
        end
        DIV_DONE: if (i_ack) r_state <= DIV_IDLE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == DIV_BUSY);
  assign o_done      = (r_state == DIV_DONE);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
endmodule

// File: rtl/ex_stage.sv
// LoongArch32 execute stage: ALU, single-cycle multiplier, iterative divider,
// data-SRAM request and hazard/forwarding outputs back to ID.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                id_ready_go,
  output logic                ex_allow_in,
  input  logic [31:0]         pc_from_id,
  input  logic [31:0]         inst_from_id,
  input  logic [ALU_OP_W-1:0] alu_op_from_id,
  input  logic [31:0]         src1_from_id,
  input  logic [31:0]         src2_from_id,
  input  logic [31:0]         st_data_from_id,
  input  logic [4:0]          dest_from_id,
  input  logic                reg_en_from_id,
  input  logic [1:0]          mem_en_from_id,
  input  logic                div_en_from_id,
  output logic                ex_ready_go,
  input  logic                mem_allow_in,
  output logic [31:0]         pc_ex,
  output logic [31:0]         inst_ex,
  output logic [31:0]         result_ex,
  output logic [4:0]          dest_ex,
  output logic                reg_en_ex,
  output logic                load_ex,
  ex_stage_if.master          dmem,
  output logic [4:0]          ex_dest,
  output logic                ex_reg_en_valid,
  output logic [31:0]         forward_data_from_exe,
  output logic                forward_en_from_exe
);
  logic                r_valid, r_reg_en, r_div_en;
  logic [31:0]         r_pc, r_inst, r_src1, r_src2, r_st_data;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [4:0]          r_dest;
  logic [1:0]          r_mem_en;

  logic        w_in_hs, w_out_hs, w_div_busy, w_div_done, w_div_start, w_div_signed;
  logic [31:0] w_sum, w_alu, w_mulh, w_quo, w_rem, w_result;
  logic [63:0] w_prod;
  logic [4:0]  w_sh;

  assign w_in_hs  = id_ready_go & ex_allow_in;
  assign w_out_hs = ex_ready_go & mem_allow_in;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0; r_pc <= '0; r_inst <= '0; r_alu_op <= '0;
      r_src1 <= '0; r_src2 <= '0; r_st_data <= '0; r_dest <= '0;
      r_reg_en <= 1'b0; r_mem_en <= '0; r_div_en <= 1'b0;
    end else if (w_in_hs) begin
      r_valid   <= 1'b1;
      r_pc      <= pc_from_id;
      r_inst    <= inst_from_id;
      r_alu_op  <= alu_op_from_id;
      r_src1    <= src1_from_id;
      r_src2    <= src2_from_id;
      r_st_data <= st_data_from_id;
      r_dest    <= dest_from_id;
      r_reg_en  <= reg_en_from_id;
      r_mem_en  <= mem_en_from_id;
      r_div_en  <= div_en_from_id;
    end else if (w_out_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign w_sum = r_src1 + r_src2;
  assign w_sh  = r_src2[4:0];
  // One unsigned multiplier; the signed high word is corrected from it.
  assign w_prod = {32'b0, r_src1} * {32'b0, r_src2};
  assign w_mulh = w_prod[63:32] - (r_src1[31] ? r_src2 : 32'b0)
                                - (r_src2[31] ? r_src1 : 32'b0);

  assign w_alu =
      ({32{r_alu_op[ALU_OP_ADD]}}   & w_sum)
    | ({32{r_alu_op[ALU_OP_SUB]}}   & (r_src1 - r_src2))
    | ({32{r_alu_op[ALU_OP_SLT]}}   & {31'b0, $signed(r_src1) < $signed(r_src2)})
    | ({32{r_alu_op[ALU_OP_SLTU]}}  & {31'b0, r_src1 < r_src2})
    | ({32{r_alu_op[ALU_OP_AND]}}   & (r_src1 & r_src2))
    | ({32{r_alu_op[ALU_OP_NOR]}}   & ~(r_src1 | r_src2))
    | ({32{r_alu_op[ALU_OP_OR]}}    & (r_src1 | r_src2))
    | ({32{r_alu_op[ALU_OP_XOR]}}   & (r_src1 ^ r_src2))
    | ({32{r_alu_op[ALU_OP_SLL]}}   & (r_src1 << w_sh))
    | ({32{r_alu_op[ALU_OP_SRL]}}   & (r_src1 >> w_sh))
    | ({32{r_alu_op[ALU_OP_SRA]}}   & 32'($signed(r_src1) >>> w_sh))
    | ({32{r_alu_op[ALU_OP_LUI]}}   & r_src2)
    | ({32{r_alu_op[ALU_OP_MUL]}}   & w_prod[31:0])
    | ({32{r_alu_op[ALU_OP_MULH]}}  & w_mulh)
    | ({32{r_alu_op[ALU_OP_MULHU]}} & w_prod[63:32])
    | ({32{r_alu_op[ALU_OP_DIV] | r_alu_op[ALU_OP_DIVU]}} & w_quo)
    | ({32{r_alu_op[ALU_OP_MOD] | r_alu_op[ALU_OP_MODU]}} & w_rem);

  assign w_result = r_mem_en[0] ? w_sum : w_alu;

  assign w_div_signed = r_alu_op[ALU_OP_DIV] | r_alu_op[ALU_OP_MOD];
  assign w_div_start  = r_valid & r_div_en & ~w_div_busy & ~w_div_done;

  ex_divider #(.DIV_ITER(DIV_ITER)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (w_div_start),
    .i_signed   (w_div_signed),
    .i_ack      (w_out_hs),
    .i_a        (r_src1),
    .i_b        (r_src2),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo),
    .o_remainder(w_rem)
  );

  assign ex_ready_go = r_valid & (~r_div_en | w_div_done);
  assign ex_allow_in = ~r_valid | w_out_hs;

  assign pc_ex     = r_pc;
  assign inst_ex   = r_inst;
  assign result_ex = w_result;
  assign dest_ex   = r_dest;
  assign reg_en_ex = r_reg_en;
  assign load_ex   = (r_mem_en == MEM_EN_LOAD);

  // Gated by the output handshake so a MEM stall never repeats the request.
  assign dmem.data_sram_en    = r_valid & r_mem_en[0] & ex_ready_go & mem_allow_in;
  assign dmem.data_sram_we    = (r_mem_en == MEM_EN_STORE) ? 4'hF : 4'h0;
  assign dmem.data_sram_addr  = w_sum;
  assign dmem.data_sram_wdata = r_st_data;

  assign ex_dest               = r_dest;
  assign ex_reg_en_valid       = r_valid & r_reg_en;
  assign forward_data_from_exe = w_result;
  assign forward_en_from_exe   = ~load_ex & ~(r_div_en & ~w_div_done);
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: results are queued at issue and compared
// when EX hands off to MEM; latency, stall and reset cases checked inline.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn, id_ready_go, ex_allow_in, reg_en_from_id, div_en_from_id;
  logic [31:0]         pc_from_id, inst_from_id, src1_from_id, src2_from_id, st_data_from_id;
  logic [ALU_OP_W-1:0] alu_op_from_id;
  logic [4:0]          dest_from_id, dest_ex, ex_dest;
  logic [1:0]          mem_en_from_id;
  logic                ex_ready_go, mem_allow_in, reg_en_ex, load_ex, ex_reg_en_valid, forward_en_from_exe;
  logic [31:0]         pc_ex, inst_ex, result_ex, forward_data_from_exe;

  ex_stage_if dmem();

  ex_stage #(.DIV_ITER(32)) dut (
    .clk(clk), .resetn(resetn), .id_ready_go(id_ready_go), .ex_allow_in(ex_allow_in),
    .pc_from_id(pc_from_id), .inst_from_id(inst_from_id), .alu_op_from_id(alu_op_from_id),
    .src1_from_id(src1_from_id), .src2_from_id(src2_from_id), .st_data_from_id(st_data_from_id),
    .dest_from_id(dest_from_id), .reg_en_from_id(reg_en_from_id), .mem_en_from_id(mem_en_from_id),
    .div_en_from_id(div_en_from_id), .ex_ready_go(ex_ready_go), .mem_allow_in(mem_allow_in),
    .pc_ex(pc_ex), .inst_ex(inst_ex), .result_ex(result_ex), .dest_ex(dest_ex),
    .reg_en_ex(reg_en_ex), .load_ex(load_ex), .dmem(dmem), .ex_dest(ex_dest),
    .ex_reg_en_valid(ex_reg_en_valid), .forward_data_from_exe(forward_data_from_exe),
    .forward_en_from_exe(forward_en_from_exe)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    string       tag;
  } exp_t;
  exp_t scb[$];

  // Independent reference using 64-bit arithmetic and explicit corner cases.
  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, ps;
    logic [63:0] pu;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ps  = sa * sbv;
    pu  = {32'b0, a} * {32'b0, b};
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return 32'($signed(a) >>> b[4:0]);
      11: return b;
      12: return pu[31:0];
      13: return ps[63:32];
      14: return pu[63:32];
      15: if (b == 0) return a[31] ? 32'd1 : 32'hFFFFFFFF;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
          else return 32'(sa / sbv);
      16: if (b == 0) return a;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
          else return 32'(sa % sbv);
      17: return (b == 0) ? 32'hFFFFFFFF : a / b;
      18: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && ex_ready_go && mem_allow_in) begin
        if (scb.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
        else begin
          e = scb.pop_front();
          chk({e.tag, "_res"}, result_ex, e.res);
          chk({e.tag, "_dest"}, {27'b0, dest_ex}, {27'b0, e.dest});
        end
      end
    end
  end

  int dest_ctr = 1;

  task automatic issue(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] mem = 2'b00, input logic [31:0] st = 32'h0);
    exp_t e;
    logic hs;
    id_ready_go     = 1'b1;
    pc_from_id      = 32'h1C00_0000 + 32'(dest_ctr * 4);
    inst_from_id    = 32'(dest_ctr);
    alu_op_from_id  = ALU_OP_W'(1) << op;
    src1_from_id    = a;
    src2_from_id    = b;
    st_data_from_id = st;
    dest_from_id    = 5'(dest_ctr);
    reg_en_from_id  = (mem != MEM_EN_STORE);
    mem_en_from_id  = mem;
    div_en_from_id  = (op >= 15);
    e.res = model(op, a, b); e.dest = 5'(dest_ctr); e.tag = tag;
    scb.push_back(e);
    dest_ctr = (dest_ctr % 31) + 1;
    hs = 1'b0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = ex_allow_in;
      @(posedge clk); #1;
    end
    if (!hs) chk({tag, "_issue_timeout"}, 32'd0, 32'd1);
    id_ready_go = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && scb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(scb.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    logic fwd_bad;
    resetn = 1'b0; id_ready_go = 1'b0; mem_allow_in = 1'b1;
    pc_from_id = '0; inst_from_id = '0; alu_op_from_id = '0; src1_from_id = '0;
    src2_from_id = '0; st_data_from_id = '0; dest_from_id = '0; reg_en_from_id = 1'b0;
    mem_en_from_id = '0; div_en_from_id = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ex_ready_go}, 32'd0);
    chk("rst_allow", {31'b0, ex_allow_in}, 32'd1);
    chk("rst_sram_en", {31'b0, dmem.data_sram_en}, 32'd0);
    chk("rst_regen_valid", {31'b0, ex_reg_en_valid}, 32'd0);
    resetn = 1'b1;

    issue("add", 0, 32'd7, 32'hFFFFFFFF);
    chk("add_ready", {31'b0, ex_ready_go}, 32'd1);
    chk("add_result", result_ex, 32'd6);
    chk("add_fwd_en", {31'b0, forward_en_from_exe}, 32'd1);
    chk("add_fwd_data", forward_data_from_exe, 32'd6);

    issue("mulh", 13, 32'h80000000, 32'd2);
    issue("mulhu", 14, 32'h80000000, 32'd2);
    issue("mul", 12, 32'h80000000, 32'd2);
    issue("sub", 1, 32'd3, 32'd5);
    issue("slt", 2, 32'hFFFFFFFF, 32'd1);
    issue("sltu", 3, 32'hFFFFFFFF, 32'd1);
    issue("sra", 10, 32'h80000000, 32'h0000_0024);
    issue("srl", 9, 32'h80000000, 32'd31);
    issue("sll", 8, 32'h1, 32'hFFFF_FFE5);
    issue("nor", 5, 32'h0F0F0000, 32'h000000F0);
    issue("lui", 11, 32'h12345678, 32'hABCDE000);
    for (int i = 0; i < 24; i++)
      issue("rnd_alu", int'($urandom_range(0, 14)), $urandom, $urandom);
    wait_drain();

    issue("divw", 15, 32'hFFFFFFF9, 32'd2);
    cyc = 0; fwd_bad = forward_en_from_exe;
    while (!ex_ready_go && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!ex_ready_go && forward_en_from_exe) fwd_bad = 1'b1;
    end
    chk("div_latency", 32'(cyc), 32'd33);
    chk("div_fwd_busy", {31'b0, fwd_bad}, 32'd0);
    chk("div_fwd_done", {31'b0, forward_en_from_exe}, 32'd1);
    issue("modw", 16, 32'hFFFFFFF9, 32'd2);
    issue("divwu_z", 17, 32'd5, 32'd0);
    issue("modwu_z", 18, 32'd5, 32'd0);
    issue("divw_ovf", 15, 32'h80000000, 32'hFFFFFFFF);
    issue("modw_ovf", 16, 32'h80000000, 32'hFFFFFFFF);
    issue("divw_zneg", 15, 32'hFFFFFFF0, 32'd0);
    for (int i = 0; i < 4; i++)
      issue("rnd_div", 15 + i, $urandom, (i == 2) ? 32'd0 : $urandom_range(1, 1000));
    wait_drain();

    mem_allow_in = 1'b0;
    issue("st", 0, 32'h100, 32'd4, MEM_EN_STORE, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      chk("st_stall_en", {31'b0, dmem.data_sram_en}, 32'd0);
      @(posedge clk); #1;
    end
    mem_allow_in = 1'b1;
    #1;
    chk("st_en", {31'b0, dmem.data_sram_en}, 32'd1);
    chk("st_addr", dmem.data_sram_addr, 32'h104);
    chk("st_we", {28'b0, dmem.data_sram_we}, 32'hF);
    chk("st_wdata", dmem.data_sram_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("st_single", {31'b0, dmem.data_sram_en}, 32'd0);

    issue("ld", 0, 32'h200, 32'd8, MEM_EN_LOAD);
    chk("ld_load", {31'b0, load_ex}, 32'd1);
    chk("ld_fwd_en", {31'b0, forward_en_from_exe}, 32'd0);
    chk("ld_en", {31'b0, dmem.data_sram_en}, 32'd1);
    chk("ld_we", {28'b0, dmem.data_sram_we}, 32'd0);
    wait_drain();

    issue("div_rst", 17, 32'd1000, 32'd7);
    repeat (11) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    scb.delete();
    chk("rst_busy_ready", {31'b0, ex_ready_go}, 32'd0);
    chk("rst_busy_allow", {31'b0, ex_allow_in}, 32'd1);
    issue("add_after_rst", 0, 32'd40, 32'd2);
    chk("post_rst_ready", {31'b0, ex_ready_go}, 32'd1);
    chk("post_rst_result", result_ex, 32'd42);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
